// File: rtl/chord_arbiter.sv
// chord_arbiter
// Two-requester round-robin front end that shares one CORDIC core.
// Each grant registers the requester's command into the core input. It also
// pushes the owner ID into a tag FIFO. Core results pop that FIFO, and each
// result is steered into the owner's first-word-fall-through result buffer.
// Per-requester credits limit in-flight plus buffered results to
// RESULT_DEPTH, so neither the buffers nor the tag FIFO can overflow.
//
// Ports
//   clk, reset                       clock, async active-low reset (release is synchronised)
//   reqN_valid/data/ready            command handshake from requester N
//   rspN_valid/data/ready            result handshake to requester N
//   pipe_in_interface/valid_in       registered command strobe to the core
//   pipe_out_interface/valid_out     core result strobe (no backpressure)
//   err_orphan                       sticky: a core result arrived with no outstanding tag
// Optional build macro
//   CHORD_ARB_STATS_EN               adds stat_grant0/stat_grant1 saturating grant counters
module chord_arbiter #(
   parameter int RESULT_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [31:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [31:0] req1_data,
   output logic        req1_ready,
   output logic        rsp0_valid,
   output logic [31:0] rsp0_data,
   input  logic        rsp0_ready,
   output logic        rsp1_valid,
   output logic [31:0] rsp1_data,
   input  logic        rsp1_ready,
   output logic [31:0] pipe_in_interface,
   output logic        pipe_valid_in_interface,
   input  logic [31:0] pipe_out_interface,
   input  logic        pipe_valid_out_interface,
   output logic        err_orphan
`ifdef CHORD_ARB_STATS_EN
   ,
   output logic [15:0] stat_grant0,
   output logic [15:0] stat_grant1
`endif
);
   localparam int TAG_DEPTH = 2 * RESULT_DEPTH;
   localparam int PW        = $clog2(RESULT_DEPTH);
   localparam int TW        = $clog2(TAG_DEPTH);
   localparam int CW        = PW + 1;
   localparam int TCW       = TW + 1;

   // Reset release is synchronised. run_q mirrors rst_sync_q[1] so that the
   // internal reset net only ever drives async reset pins.
   logic [1:0] rst_sync_q, rst_sync_d;
   logic       run_q, run_d;
   logic       rst_n;

   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   assign run_d      = rst_sync_q[0];
   assign rst_n      = rst_sync_q[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_sync_q <= '0;
         run_q      <= 1'b0;
      end else begin
         rst_sync_q <= rst_sync_d;
         run_q      <= run_d;
      end
   end

   logic [1:0]           req_valid, rsp_ready, elig, grant, rsp_valid, rsp_hs;
   logic [CW-1:0]        credit_q [2], credit_d [2];
   logic                 last_grant_q, last_grant_d;
   logic [31:0]          pipe_in_q, pipe_in_d;
   logic                 pipe_valid_q, pipe_valid_d;
   logic [TAG_DEPTH-1:0] tag_q, tag_d;
   logic [TW-1:0]        tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
   logic [TCW-1:0]       tag_cnt_q, tag_cnt_d;
   logic                 tag_pop, tag_owner, orphan;
   logic [31:0]          buf_q [2][RESULT_DEPTH], buf_d [2][RESULT_DEPTH];
   logic [PW-1:0]        buf_wr_q [2], buf_wr_d [2], buf_rd_q [2], buf_rd_d [2];
   logic [CW-1:0]        buf_cnt_q [2], buf_cnt_d [2];
   logic                 err_q, err_d;

   assign req_valid = {req1_valid, req0_valid};
   assign rsp_ready = {rsp1_ready, rsp0_ready};

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         elig[i]      = run_q && req_valid[i] && (credit_q[i] < CW'(RESULT_DEPTH));
         rsp_valid[i] = (buf_cnt_q[i] != '0);
         rsp_hs[i]    = rsp_valid[i] && rsp_ready[i];
      end
      // last_grant_q=1 means requester 1 went last, so requester 0 wins a tie
      grant[0] = elig[0] && (!elig[1] || last_grant_q);
      grant[1] = elig[1] && (!elig[0] || !last_grant_q);
   end

   assign tag_owner = tag_q[tag_rd_q];
   assign tag_pop   = pipe_valid_out_interface && (tag_cnt_q != '0);
   assign orphan    = pipe_valid_out_interface && (tag_cnt_q == '0);

   always_comb begin
      last_grant_d = last_grant_q;
      pipe_in_d    = pipe_in_q;
      pipe_valid_d = |grant;
      tag_d        = tag_q;
      tag_wr_d     = tag_wr_q;
      tag_rd_d     = tag_rd_q;
      buf_d        = buf_q;
      if (grant[0]) begin
         last_grant_d = 1'b0;
         pipe_in_d    = req0_data;
      end else if (grant[1]) begin
         last_grant_d = 1'b1;
         pipe_in_d    = req1_data;
      end
      if (|grant) begin
         tag_d[tag_wr_q] = grant[1];
         tag_wr_d        = tag_wr_q + 1'b1;
      end
      if (tag_pop) tag_rd_d = tag_rd_q + 1'b1;
      tag_cnt_d = tag_cnt_q + TCW'(|grant) - TCW'(tag_pop);
      err_d     = err_q | orphan;
      for (int i = 0; i < 2; i++) begin
         buf_wr_d[i] = buf_wr_q[i];
         buf_rd_d[i] = buf_rd_q[i];
         if (tag_pop && (tag_owner == i[0])) begin
            buf_d[i][buf_wr_q[i]] = pipe_out_interface;
            buf_wr_d[i]           = buf_wr_q[i] + 1'b1;
         end
         if (rsp_hs[i]) buf_rd_d[i] = buf_rd_q[i] + 1'b1;
         buf_cnt_d[i] = buf_cnt_q[i] + CW'(tag_pop && (tag_owner == i[0])) - CW'(rsp_hs[i]);
         credit_d[i]  = credit_q[i] + CW'(grant[i]) - CW'(rsp_hs[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
         pipe_in_q    <= '0;
         pipe_valid_q <= 1'b0;
         tag_q        <= '0;
         tag_wr_q     <= '0;
         tag_rd_q     <= '0;
         tag_cnt_q    <= '0;
         err_q        <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            credit_q[i]  <= '0;
            buf_wr_q[i]  <= '0;
            buf_rd_q[i]  <= '0;
            buf_cnt_q[i] <= '0;
            for (int j = 0; j < RESULT_DEPTH; j++) buf_q[i][j] <= '0;
         end
      end else begin
         last_grant_q <= last_grant_d;
         pipe_in_q    <= pipe_in_d;
         pipe_valid_q <= pipe_valid_d;
         tag_q        <= tag_d;
         tag_wr_q     <= tag_wr_d;
         tag_rd_q     <= tag_rd_d;
         tag_cnt_q    <= tag_cnt_d;
         err_q        <= err_d;
         credit_q     <= credit_d;
         buf_wr_q     <= buf_wr_d;
         buf_rd_q     <= buf_rd_d;
         buf_cnt_q    <= buf_cnt_d;
         buf_q        <= buf_d;
      end
   end

   assign req0_ready              = grant[0];
   assign req1_ready              = grant[1];
   assign rsp0_valid              = rsp_valid[0];
   assign rsp1_valid              = rsp_valid[1];
   assign rsp0_data               = rsp_valid[0] ? buf_q[0][buf_rd_q[0]] : '0;
   assign rsp1_data               = rsp_valid[1] ? buf_q[1][buf_rd_q[1]] : '0;
   assign pipe_in_interface       = pipe_in_q;
   assign pipe_valid_in_interface = pipe_valid_q;
   assign err_orphan              = err_q;

`ifdef CHORD_ARB_STATS_EN
   logic [15:0] stat_q [2], stat_d [2];

   always_comb begin
      for (int i = 0; i < 2; i++)
         stat_d[i] = (grant[i] && (stat_q[i] != 16'hFFFF)) ? stat_q[i] + 16'd1 : stat_q[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_q[0] <= '0;
         stat_q[1] <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end

   assign stat_grant0 = stat_q[0];
   assign stat_grant1 = stat_q[1];
`endif
endmodule

// File: tb/tb_chord_arbiter.sv
`timescale 1ns/1ps
module tb_chord_arbiter;
   localparam int D   = 4;
   localparam int LAT = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [31:0] req0_data, req1_data;
   logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
   logic [31:0] rsp0_data, rsp1_data;
   logic [31:0] pipe_in_interface, pipe_out_interface;
   logic        pipe_valid_in_interface, pipe_valid_out_interface;
   logic        err_orphan;
`ifdef CHORD_ARB_STATS_EN
   logic [15:0] stat_grant0, stat_grant1;
`endif

   always #5 clk = ~clk;

   chord_arbiter #(.RESULT_DEPTH(D)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
      .pipe_in_interface(pipe_in_interface), .pipe_valid_in_interface(pipe_valid_in_interface),
      .pipe_out_interface(pipe_out_interface), .pipe_valid_out_interface(pipe_valid_out_interface),
      .err_orphan(err_orphan)
`ifdef CHORD_ARB_STATS_EN
      , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1)
`endif
   );

   int total = 0;
   int bad   = 0;

   // reference model: credits, owner order, per-requester result queues
   int          m_credit [2];
   bit          m_last, m_err, m_pv;
   logic [31:0] m_pin;
   int          m_rst_cnt;
   int          m_sg0, m_sg1;
   int          tagq [$];
   logic [31:0] m_buf0 [$], m_buf1 [$], iss0 [$], iss1 [$];

   // behavioural CORDIC stand-in: fixed latency, fixed transform
   bit          core_v [LAT];
   logic [31:0] core_d [LAT];
   bit          cap_v, inject;
   logic [31:0] cap_d;

   int vm0, vm1, rm0, rm1;
   int obs_g0, obs_g1, obs_rsp0;
   int gseq [$];

   function automatic logic [31:0] core_f(input logic [31:0] x);
      return {x[15:0], x[31:16]} ^ 32'hC0DE_1234;
   endfunction

   function automatic logic pick(input int m);
      if (m == 1) return 1'b1;
      if (m == 2) return 1'($urandom_range(0, 1));
      return 1'b0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_credit[0] = 0; m_credit[1] = 0;
      m_last = 1'b1; m_err = 1'b0; m_pv = 1'b0; m_pin = '0;
      m_rst_cnt = 0; m_sg0 = 0; m_sg1 = 0;
      tagq.delete(); m_buf0.delete(); m_buf1.delete(); iss0.delete(); iss1.delete();
   endtask

   task automatic drive_inputs();
      req0_valid = pick(vm0);
      req1_valid = pick(vm1);
      rsp0_ready = pick(rm0);
      rsp1_ready = pick(rm1);
      req0_data  = $urandom;
      req1_data  = $urandom;
   endtask

   task automatic step();
      bit en, e0, e1, g0, g1, hs0, hs1;
      int o;
      @(negedge clk);
      en = reset && (m_rst_cnt >= 2);
      g0 = 1'b0; g1 = 1'b0;
      if (en) begin
         e0 = req0_valid && (m_credit[0] < D);
         e1 = req1_valid && (m_credit[1] < D);
         g0 = e0 && (!e1 || m_last);
         g1 = e1 && (!e0 || !m_last);
      end
      chk("req0_ready", 32'(req0_ready), 32'(g0));
      chk("req1_ready", 32'(req1_ready), 32'(g1));
      chk("rsp0_valid", 32'(rsp0_valid), 32'(m_buf0.size() > 0));
      chk("rsp1_valid", 32'(rsp1_valid), 32'(m_buf1.size() > 0));
      if (m_buf0.size() > 0) chk("rsp0_data", rsp0_data, m_buf0[0]);
      else if (!en) chk("rsp0_data_rst", rsp0_data, 32'h0);
      if (m_buf1.size() > 0) chk("rsp1_data", rsp1_data, m_buf1[0]);
      else if (!en) chk("rsp1_data_rst", rsp1_data, 32'h0);
      chk("pipe_valid_in", 32'(pipe_valid_in_interface), 32'(m_pv));
      chk("pipe_in", pipe_in_interface, m_pin);
      chk("err_orphan", 32'(err_orphan), 32'(m_err));
      if (req0_ready) obs_g0++;
      if (req1_ready) obs_g1++;
      if (req0_ready || req1_ready) gseq.push_back(int'(req1_ready));
      if (rsp0_valid && rsp0_ready) obs_rsp0++;
      cap_v = pipe_valid_in_interface;
      cap_d = pipe_in_interface;
      if (en) begin
         hs0 = (m_buf0.size() > 0) && rsp0_ready;
         hs1 = (m_buf1.size() > 0) && rsp1_ready;
         if (hs0) begin
            void'(m_buf0.pop_front());
            if (iss0.size() > 0) chk("order0", rsp0_data, core_f(iss0.pop_front()));
         end
         if (hs1) begin
            void'(m_buf1.pop_front());
            if (iss1.size() > 0) chk("order1", rsp1_data, core_f(iss1.pop_front()));
         end
         if (pipe_valid_out_interface) begin
            if (tagq.size() > 0) begin
               o = tagq.pop_front();
               if (o == 0) m_buf0.push_back(pipe_out_interface);
               else        m_buf1.push_back(pipe_out_interface);
            end else begin
               m_err = 1'b1;
            end
         end
         if (g0) begin tagq.push_back(0); iss0.push_back(req0_data); m_sg0++; end
         if (g1) begin tagq.push_back(1); iss1.push_back(req1_data); m_sg1++; end
         m_credit[0] += int'(g0) - int'(hs0);
         m_credit[1] += int'(g1) - int'(hs1);
         if (g0) m_last = 1'b0;
         else if (g1) m_last = 1'b1;
         m_pv = g0 || g1;
         if (g0) m_pin = req0_data;
         else if (g1) m_pin = req1_data;
      end
      @(posedge clk);
      if (reset && m_rst_cnt < 2) m_rst_cnt++;
      #1;
      for (int k = LAT - 1; k > 0; k--) begin
         core_v[k] = core_v[k-1];
         core_d[k] = core_d[k-1];
      end
      core_v[0] = cap_v;
      core_d[0] = core_f(cap_d);
      pipe_valid_out_interface = core_v[LAT-1] | inject;
      pipe_out_interface       = core_v[LAT-1] ? core_d[LAT-1] : $urandom;
      inject = 1'b0;
      drive_inputs();
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0;
      model_clear();
      repeat (n) step();
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
      req0_data = '0; req1_data = '0;
      pipe_valid_out_interface = 0; pipe_out_interface = '0;
      inject = 0; cap_v = 0; cap_d = '0;
      vm0 = 0; vm1 = 0; rm0 = 0; rm1 = 0;
      obs_g0 = 0; obs_g1 = 0; obs_rsp0 = 0;
      for (int k = 0; k < LAT; k++) begin core_v[k] = 0; core_d[k] = '0; end
      #1;
      do_reset(3);
      repeat (4) step();

      // orphan result with nothing issued
      inject = 1'b1;
      repeat (6) step();
      chk("orphan_sticky", 32'(err_orphan), 32'h1);

      // alternation with both requesters always valid
      vm0 = 1; vm1 = 1; rm0 = 1; rm1 = 1;
      gseq.delete();
      do_reset(2);
      repeat (60) step();
      for (int k = 0; k < 4; k++)
         chk("alternate", (k < gseq.size()) ? 32'(gseq[k]) : 32'hFFFF_FFFF, 32'(k % 2));
      vm0 = 0; vm1 = 0;
      repeat (30) step();

      // credit limit with requester 0 stalled on its responses
      vm0 = 1; vm1 = 0; rm0 = 0; rm1 = 0;
      do_reset(2);
      obs_g0 = 0;
      repeat (30) step();
      chk("credit_grants", 32'(obs_g0), 32'(D));
      rsp0_ready = 1'b1;
      step();
      obs_g0 = 0;
      repeat (6) step();
      chk("credit_regrant", 32'(obs_g0), 32'h1);

      // reset with three commands in flight
      vm0 = 0; rm0 = 1;
      do_reset(2);
      repeat (3) step();
      vm0 = 1; req0_valid = 1'b1;
      obs_g0 = 0;
      repeat (3) step();
      chk("inflight_grants", 32'(obs_g0), 32'h3);
      vm0 = 0; req0_valid = 1'b0;
      step();
      do_reset(1);
      repeat (20) step();
      chk("late_orphan", 32'(err_orphan), 32'h1);
      obs_rsp0 = 0;
      req0_valid = 1'b1;
      step();
      repeat (20) step();
      chk("post_reset_rsp", 32'(obs_rsp0), 32'h1);

      // randomized mixed traffic, then drain
      vm0 = 2; vm1 = 2; rm0 = 2; rm1 = 2;
      repeat (400) step();
      vm0 = 0; vm1 = 0; rm0 = 1; rm1 = 1;
      repeat (40) step();
      chk("drain_empty0", 32'(rsp0_valid), 32'h0);
      chk("drain_empty1", 32'(rsp1_valid), 32'h0);
`ifdef CHORD_ARB_STATS_EN
      chk("stat_grant0", 32'(stat_grant0), 32'((m_sg0 > 65535) ? 65535 : m_sg0));
      chk("stat_grant1", 32'(stat_grant1), 32'((m_sg1 > 65535) ? 65535 : m_sg1));
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
